// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MAT_WAIT = 2'd1,
    DRAIN    = 2'd2
  } mat_state_t;

  // $clog2 that never returns 0, so one-entry tables still get a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hazard_addr_table.sv
// NPU in-flight write-address table: per-channel valid/address, CPU address
// match vector and lowest-index priority encode of the matching channel.
module hazard_addr_table
  import hazard_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int ADDR_W = 10,
  localparam int CH_W  = clog2_min1(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic [CH_W-1:0]   set_ch,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr,
  input  logic [CH_W-1:0]   clr_ch,
  input  logic              lookup_en,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit_any,
  output logic [CH_W-1:0]   hit_ch
);

  logic [NCH-1:0]    valid;
  logic [ADDR_W-1:0] addr [NCH];
  logic [NCH-1:0]    hit;

  // A set on the same channel as a clear takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < NCH; i++) addr[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (set && (set_ch == CH_W'(i))) begin
          valid[i] <= 1'b1;
          addr[i]  <= set_addr;
        end else if (clr && (clr_ch == CH_W'(i))) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = valid[i] && lookup_en && (addr[i] == lookup_addr);
    end
  end

  assign hit_any = |hit;

  always_comb begin
    hit_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit[i]) hit_ch = CH_W'(i);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: merges load-use, matrix-operation window and
// NPU write-address conflicts into STALL. Optional stall statistics via HAZARD_STATS_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no matrix operation in flight; MAT_START opens the window
// MAT_WAIT | waiting for MAT_DONE; down-counter aborts at terminal count
// DRAIN    | holds the stall DRAIN_CYC cycles after MAT_DONE
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int ADDR_W    = 10,
  parameter int NCH       = 4,
  parameter int DRAIN_CYC = 2,
  parameter int MAT_TMO   = 1024,
  localparam int CH_W     = clog2_min1(NCH)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              MEMRead,
  input  logic [REG_AW-1:0] RD,
  input  logic [REG_AW-1:0] RS1,
  input  logic [REG_AW-1:0] RS2,
  input  logic              RS1_USE,
  input  logic              RS2_USE,
  input  logic              MAT_START,
  input  logic              MAT_DONE,
  input  logic              NPU_WR_SET,
  input  logic              NPU_WR_CLR,
  input  logic [CH_W-1:0]   NPU_CH,
  input  logic [CH_W-1:0]   NPU_CLR_CH,
  input  logic [ADDR_W-1:0] NPU_ADDR,
  input  logic              CPU_MEM_EN,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic              STALL,
  output logic              CRITICAL,
  output logic [CH_W-1:0]   CRIT_CH,
  output logic              MAT_ERR
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       STALL_CNT,
  output logic [15:0]       CRIT_CNT
`endif
);

  localparam int CNT_MAX  = (MAT_TMO > DRAIN_CYC) ? MAT_TMO : DRAIN_CYC;
  localparam int CNT_W    = clog2_min1(CNT_MAX);
  localparam int DRAIN_LV = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(MAT_TMO - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_LV);

  mat_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             lu;
  logic             mat;
  logic             crit;
  logic [CH_W-1:0]  hit_ch;

  // One down-counter serves both the MAT_WAIT timeout and the DRAIN hold.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      cnt     <= '0;
      MAT_ERR <= 1'b0;
    end else begin
      MAT_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (MAT_START) begin
            state <= MAT_WAIT;
            cnt   <= TMO_LD;
          end
        end
        MAT_WAIT: begin
          if (MAT_DONE) begin
            if (DRAIN_CYC == 0) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              state <= DRAIN;
              cnt   <= DRAIN_LD;
            end
          end else if (cnt == '0) begin
            state   <= IDLE;
            MAT_ERR <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  hazard_addr_table #(
    .NCH    (NCH),
    .ADDR_W (ADDR_W)
  ) u_addr_table (
    .clk         (CLK),
    .rst_n       (RSTn),
    .set         (NPU_WR_SET),
    .set_ch      (NPU_CH),
    .set_addr    (NPU_ADDR),
    .clr         (NPU_WR_CLR),
    .clr_ch      (NPU_CLR_CH),
    .lookup_en   (CPU_MEM_EN),
    .lookup_addr (CPU_ADDR),
    .hit_any     (crit),
    .hit_ch      (hit_ch)
  );

  assign lu = MEMRead && (RD != '0) &&
              ((RS1_USE && (RD == RS1)) || (RS2_USE && (RD == RS2)));

  assign mat = (state != IDLE) || MAT_START;

  // Outputs are gated by RSTn so a held reset never leaks a combinational stall.
  assign STALL    = RSTn && (lu || mat || crit);
  assign CRITICAL = RSTn && crit && !lu && !mat;
  assign CRIT_CH  = CRITICAL ? hit_ch : '0;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      STALL_CNT <= '0;
      CRIT_CNT  <= '0;
    end else begin
      if (STALL && (STALL_CNT != 16'hFFFF)) STALL_CNT <= STALL_CNT + 16'd1;
      if (CRITICAL && (CRIT_CNT != 16'hFFFF)) CRIT_CNT <= CRIT_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second instance with a short
// matrix timeout exercises the MAT_WAIT abort path on shared stimulus.
module tb_hazard_ctrl;

  localparam int CH_W = 2;

  logic            CLK;
  logic            RSTn;
  logic            MEMRead;
  logic [4:0]      RD, RS1, RS2;
  logic            RS1_USE, RS2_USE;
  logic            MAT_START, MAT_DONE;
  logic            NPU_WR_SET, NPU_WR_CLR;
  logic [CH_W-1:0] NPU_CH, NPU_CLR_CH;
  logic [9:0]      NPU_ADDR;
  logic            CPU_MEM_EN;
  logic [9:0]      CPU_ADDR;

  logic            STALL, CRITICAL, MAT_ERR;
  logic [CH_W-1:0] CRIT_CH;
  logic            t_stall, t_critical, t_mat_err;
  logic [CH_W-1:0] t_crit_ch;
`ifdef HAZARD_STATS_EN
  logic [15:0]     STALL_CNT, CRIT_CNT, t_stall_cnt, t_crit_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(.REG_AW(5), .ADDR_W(10), .NCH(4), .DRAIN_CYC(2), .MAT_TMO(1024)) dut (
    .CLK(CLK), .RSTn(RSTn), .MEMRead(MEMRead), .RD(RD), .RS1(RS1), .RS2(RS2),
    .RS1_USE(RS1_USE), .RS2_USE(RS2_USE), .MAT_START(MAT_START), .MAT_DONE(MAT_DONE),
    .NPU_WR_SET(NPU_WR_SET), .NPU_WR_CLR(NPU_WR_CLR), .NPU_CH(NPU_CH),
    .NPU_CLR_CH(NPU_CLR_CH), .NPU_ADDR(NPU_ADDR), .CPU_MEM_EN(CPU_MEM_EN),
    .CPU_ADDR(CPU_ADDR), .STALL(STALL), .CRITICAL(CRITICAL), .CRIT_CH(CRIT_CH),
    .MAT_ERR(MAT_ERR)
`ifdef HAZARD_STATS_EN
    , .STALL_CNT(STALL_CNT), .CRIT_CNT(CRIT_CNT)
`endif
  );

  hazard_ctrl #(.REG_AW(5), .ADDR_W(10), .NCH(4), .DRAIN_CYC(2), .MAT_TMO(8)) dut_tmo (
    .CLK(CLK), .RSTn(RSTn), .MEMRead(MEMRead), .RD(RD), .RS1(RS1), .RS2(RS2),
    .RS1_USE(RS1_USE), .RS2_USE(RS2_USE), .MAT_START(MAT_START), .MAT_DONE(MAT_DONE),
    .NPU_WR_SET(NPU_WR_SET), .NPU_WR_CLR(NPU_WR_CLR), .NPU_CH(NPU_CH),
    .NPU_CLR_CH(NPU_CLR_CH), .NPU_ADDR(NPU_ADDR), .CPU_MEM_EN(CPU_MEM_EN),
    .CPU_ADDR(CPU_ADDR), .STALL(t_stall), .CRITICAL(t_critical), .CRIT_CH(t_crit_ch),
    .MAT_ERR(t_mat_err)
`ifdef HAZARD_STATS_EN
    , .STALL_CNT(t_stall_cnt), .CRIT_CNT(t_crit_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    MEMRead = 1'b0; RD = '0; RS1 = '0; RS2 = '0; RS1_USE = 1'b0; RS2_USE = 1'b0;
    MAT_START = 1'b0; MAT_DONE = 1'b0;
    NPU_WR_SET = 1'b0; NPU_WR_CLR = 1'b0; NPU_CH = '0; NPU_CLR_CH = '0; NPU_ADDR = '0;
    CPU_MEM_EN = 1'b0; CPU_ADDR = '0;
  endtask

  initial begin
    int pulses;
    clear_inputs();
    RSTn = 1'b0;

    // Hazard present while reset is held: outputs must stay forced low.
    MEMRead = 1'b1; RD = 5'd5; RS2 = 5'd5; RS2_USE = 1'b1; MAT_START = 1'b1;
    #2;
    check_val("rst_stall", 32'(STALL), 32'd0);
    check_val("rst_critical", 32'(CRITICAL), 32'd0);
    check_val("rst_crit_ch", 32'(CRIT_CH), 32'd0);
    check_val("rst_mat_err", 32'(MAT_ERR), 32'd0);
    clear_inputs();
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    next_cycle();

    // Load-use interlock
    MEMRead = 1'b1; RD = 5'd5; RS2 = 5'd5; RS2_USE = 1'b1; #1;
    check_val("lu_rs2_stall", 32'(STALL), 32'd1);
    check_val("lu_rs2_critical", 32'(CRITICAL), 32'd0);
    RD = 5'd0; RS2 = 5'd0; #1;
    check_val("lu_x0_stall", 32'(STALL), 32'd0);
    RD = 5'd5; RS2 = 5'd5; RS2_USE = 1'b0; #1;
    check_val("lu_nouse_stall", 32'(STALL), 32'd0);
    RD = 5'd7; RS1 = 5'd7; RS1_USE = 1'b1; #1;
    check_val("lu_rs1_stall", 32'(STALL), 32'd1);
    MEMRead = 1'b0; #1;
    check_val("lu_noload_stall", 32'(STALL), 32'd0);
    clear_inputs();
    next_cycle();

    // Matrix window: start at 10 (repeat at 15 ignored), done at 20
    for (int c = 0; c <= 26; c++) begin
      MAT_START = (c == 10) || (c == 15);
      MAT_DONE  = (c == 20);
      #1;
      check_val($sformatf("mat_stall@%0d", c), 32'(STALL), 32'((c >= 10) && (c <= 22)));
      if (c >= 10 && c <= 23) check_val($sformatf("mat_err@%0d", c), 32'(MAT_ERR), 32'd0);
      next_cycle();
    end
    clear_inputs();

    // Timeout on the MAT_TMO=8 instance; the main instance is closed by a late done
    for (int c = 0; c <= 18; c++) begin
      MAT_START = (c == 1);
      MAT_DONE  = (c == 14);
      #1;
      if (c <= 13) begin
        check_val($sformatf("tmo_stall@%0d", c), 32'(t_stall), 32'((c >= 1) && (c <= 9)));
        check_val($sformatf("tmo_err@%0d", c), 32'(t_mat_err), 32'(c == 10));
      end
      if (c == 16) check_val("drain_late_stall", 32'(STALL), 32'd1);
      if (c == 17) check_val("drain_late_idle", 32'(STALL), 32'd0);
      next_cycle();
    end
    clear_inputs();
    #1;
    check_val("idle_stall", 32'(STALL), 32'd0);

    // Write table
    NPU_WR_SET = 1'b1; NPU_CH = 2'd2; NPU_ADDR = 10'h1A4;
    next_cycle();
    NPU_CH = 2'd1;
    CPU_MEM_EN = 1'b1; CPU_ADDR = 10'h1A4; #1;
    check_val("tbl_sameset_ch", 32'(CRIT_CH), 32'd2);
    next_cycle();
    NPU_WR_SET = 1'b0; #1;
    check_val("tbl_stall", 32'(STALL), 32'd1);
    check_val("tbl_critical", 32'(CRITICAL), 32'd1);
    check_val("tbl_crit_ch1", 32'(CRIT_CH), 32'd1);
    NPU_WR_CLR = 1'b1; NPU_CLR_CH = 2'd1; #1;
    check_val("tbl_clr_pending", 32'(CRIT_CH), 32'd1);
    next_cycle();
    NPU_WR_CLR = 1'b0; #1;
    check_val("tbl_clr_ch2", 32'(CRIT_CH), 32'd2);
    NPU_WR_SET = 1'b1; NPU_CH = 2'd2; NPU_ADDR = 10'h1A4;
    NPU_WR_CLR = 1'b1; NPU_CLR_CH = 2'd2;
    next_cycle();
    NPU_WR_SET = 1'b0; NPU_WR_CLR = 1'b0; #1;
    check_val("tbl_setclr_crit", 32'(CRITICAL), 32'd1);
    check_val("tbl_setclr_ch", 32'(CRIT_CH), 32'd2);
    NPU_WR_SET = 1'b1; NPU_CH = 2'd2; NPU_ADDR = 10'h0F0;
    next_cycle();
    NPU_WR_SET = 1'b0; #1;
    check_val("tbl_ovw_old_stall", 32'(STALL), 32'd0);
    check_val("tbl_ovw_old_ch", 32'(CRIT_CH), 32'd0);
    CPU_ADDR = 10'h0F0; #1;
    check_val("tbl_ovw_new_ch", 32'(CRIT_CH), 32'd2);
    CPU_MEM_EN = 1'b0; #1;
    check_val("tbl_noen_stall", 32'(STALL), 32'd0);

    // Priority: conflict together with load-use, then with a matrix start
    CPU_MEM_EN = 1'b1;
    MEMRead = 1'b1; RD = 5'd3; RS1 = 5'd3; RS1_USE = 1'b1; #1;
    check_val("prio_lu_stall", 32'(STALL), 32'd1);
    check_val("prio_lu_critical", 32'(CRITICAL), 32'd0);
    check_val("prio_lu_crit_ch", 32'(CRIT_CH), 32'd0);
    MEMRead = 1'b0; MAT_START = 1'b1; #1;
    check_val("prio_mat_critical", 32'(CRITICAL), 32'd0);
    check_val("prio_mat_stall", 32'(STALL), 32'd1);
    NPU_WR_SET = 1'b1; NPU_CH = 2'd0; NPU_ADDR = 10'h055;
    next_cycle();
    MAT_START = 1'b0; NPU_WR_SET = 1'b0; CPU_MEM_EN = 1'b0;
    next_cycle();
    #1;
    check_val("mid_wait_stall", 32'(STALL), 32'd1);

    // Reset in the middle of MAT_WAIT with two table entries valid
    RSTn = 1'b0; #1;
    check_val("rst_mid_stall", 32'(STALL), 32'd0);
    check_val("rst_mid_err", 32'(t_mat_err), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    next_cycle();
    CPU_MEM_EN = 1'b1; CPU_ADDR = 10'h0F0; #1;
    check_val("post_rst_ch2_stall", 32'(STALL), 32'd0);
    CPU_ADDR = 10'h055; #1;
    check_val("post_rst_ch0_stall", 32'(STALL), 32'd0);
    CPU_MEM_EN = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (t_mat_err) pulses++;
      next_cycle();
    end
    check_val("post_rst_no_err", 32'(pulses), 32'd0);

`ifdef HAZARD_STATS_EN
    RSTn = 1'b0; #1;
    check_val("stats_rst", 32'(STALL_CNT), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    next_cycle();
    MEMRead = 1'b1; RD = 5'd9; RS2 = 5'd9; RS2_USE = 1'b1;
    repeat (5) next_cycle();
    check_val("stats_stall5", 32'(STALL_CNT), 32'd5);
    check_val("stats_crit0", 32'(CRIT_CNT), 32'd0);
    repeat (70000) next_cycle();
    check_val("stats_sat", 32'(STALL_CNT), 32'h0000FFFF);
    clear_inputs();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
